// File: rtl/axilite_master_arbiter.sv
// rtl/axilite_master_arbiter.sv - two-requester round-robin arbiter driving one AXI4-Lite master port
module axilite_master_arbiter #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [1:0]                        REQ,
    input  logic [1:0]                        REQ_WE,
    input  logic [2*C_S_AXI_ADDR_WIDTH-1:0]   REQ_ADDR,
    input  logic [2*C_S_AXI_DATA_WIDTH-1:0]   REQ_WDATA,
    output logic [1:0]                        ACK,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                        RESP,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, WR, WAIT_B, RD_A, RD_D, DONE} state_t;

    state_t          state_q, state_d;
    logic            grant_q;
    logic            last_grant_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic            aw_done_q;
    logic            w_done_q;
    logic [DW-1:0]   rdata_q;
    logic [1:0]      resp_q;
    logic            pick;

    // With both requesting, the one not served last wins; otherwise the lone requester wins.
    assign pick = (REQ == 2'b11) ? ~last_grant_q : REQ[1];

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = '1;
    assign RDATA        = rdata_q;
    assign RESP         = resp_q;

    // State register plus grant latch, handshake tracking and response capture.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            rdata_q      <= '0;
            resp_q       <= 2'b00;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && REQ != 2'b00) begin
                grant_q      <= pick;
                last_grant_q <= pick;
                addr_q       <= pick ? REQ_ADDR[2*AW-1:AW] : REQ_ADDR[AW-1:0];
                wdata_q      <= pick ? REQ_WDATA[2*DW-1:DW] : REQ_WDATA[DW-1:0];
                aw_done_q    <= 1'b0;
                w_done_q     <= 1'b0;
            end
            if (state_q == WR) begin
                if (M_AXI_AWREADY) aw_done_q <= 1'b1;
                if (M_AXI_WREADY)  w_done_q  <= 1'b1;
            end
            if (state_q == WAIT_B && M_AXI_BVALID) begin
                resp_q <= M_AXI_BRESP;
            end
            if (state_q == RD_D && M_AXI_RVALID) begin
                rdata_q <= M_AXI_RDATA;
                resp_q  <= M_AXI_RRESP;
            end
        end
    end

    // Next-state decode and per-state channel handshake outputs.
    always_comb begin
        state_d       = state_q;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        ACK           = 2'b00;
        case (state_q)
            IDLE: begin
                if (REQ != 2'b00) state_d = REQ_WE[pick] ? WR : RD_A;
            end
            WR: begin
                M_AXI_AWVALID = ~aw_done_q;
                M_AXI_WVALID  = ~w_done_q;
                // A channel counts as done if it finished earlier or handshakes this cycle.
                if ((aw_done_q || M_AXI_AWREADY) && (w_done_q || M_AXI_WREADY)) state_d = WAIT_B;
            end
            WAIT_B: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) state_d = DONE;
            end
            RD_A: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) state_d = RD_D;
            end
            RD_D: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) state_d = DONE;
            end
            DONE: begin
                ACK     = grant_q ? 2'b10 : 2'b01;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axilite_master_arbiter.sv
// tb/tb_axilite_master_arbiter.sv - directed self-checking bench for axilite_master_arbiter
module tb_axilite_master_arbiter;
    localparam int DW = 32;
    localparam int AW = 12;

    logic            clk = 1'b0;
    logic            resetn;
    logic [1:0]      req, req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      ack;
    logic [DW-1:0]   rdata;
    logic [1:0]      resp;
    logic [AW-1:0]   awaddr, araddr;
    logic            awvalid, awready, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rvalid, rready;
    logic [DW-1:0]   wdata, m_rdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0]      bresp, rresp;

    int total = 0;
    int bad   = 0;

    axilite_master_arbiter #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(resetn),
        .REQ(req), .REQ_WE(req_we), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
        .ACK(ack), .RDATA(rdata), .RESP(resp),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        logic [1:0] exp_ack;
        resetn = 1'b0; req = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; m_rdata = '0;
        @(negedge clk);
        cyc(); cyc();
        chk("rst_ack", ack, 2'b00);
        chk("rst_valids", {awvalid, wvalid, arvalid}, 3'b000);
        chk("rst_readys", {bready, rready}, 2'b00);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_resp", resp, 2'b00);

        // Requester 0 write, AW and W ready together
        resetn = 1'b1;
        req = 2'b01; req_we = 2'b01; req_addr[AW-1:0] = 12'h000; req_wdata[DW-1:0] = 32'h55555555;
        awready = 1; wready = 1;
        cyc();
        chk("wr_valids", {awvalid, wvalid}, 2'b11);
        chk("wr_awaddr", awaddr, 12'h000);
        chk("wr_wdata", wdata, 32'h55555555);
        chk("wr_wstrb", wstrb, 4'hF);
        cyc();
        chk("wr_valids_drop", {awvalid, wvalid}, 2'b00);
        chk("wr_bready", bready, 1'b1);
        chk("wr_ack_early", ack, 2'b00);
        bvalid = 1; bresp = 2'b00;
        cyc();
        chk("wr_ack", ack, 2'b01);
        chk("wr_resp", resp, 2'b00);
        bvalid = 0; req = 2'b00; awready = 0; wready = 0;
        cyc();
        chk("wr_ack_pulse", ack, 2'b00);

        // Requester 1 read of 0x004
        req = 2'b10; req_we = 2'b00; req_addr[2*AW-1:AW] = 12'h004;
        cyc();
        chk("rd_arvalid", arvalid, 1'b1);
        chk("rd_araddr", araddr, 12'h004);
        chk("rd_no_aw", awvalid, 1'b0);
        arready = 1;
        cyc();
        chk("rd_arvalid_drop", arvalid, 1'b0);
        chk("rd_rready", rready, 1'b1);
        arready = 0; rvalid = 1; m_rdata = 32'hAAAAAAAA; rresp = 2'b00;
        cyc();
        chk("rd_ack", ack, 2'b10);
        chk("rd_rdata", rdata, 32'hAAAAAAAA);
        chk("rd_resp", resp, 2'b00);
        chk("rd_rready_done", rready, 1'b0);
        rvalid = 0; m_rdata = '0; req = 2'b00;
        cyc();
        chk("rd_rdata_hold", rdata, 32'hAAAAAAAA);
        chk("rd_ack_pulse", ack, 2'b00);

        // Requester 0 write: AWREADY three cycles ahead of WREADY, then SLVERR
        req = 2'b01; req_we = 2'b01; req_addr[AW-1:0] = 12'h010; req_wdata[DW-1:0] = 32'h12345678;
        awready = 1; wready = 0;
        cyc();
        chk("skew_valids0", {awvalid, wvalid}, 2'b11);
        cyc();
        chk("skew_valids1", {awvalid, wvalid}, 2'b01);
        chk("skew_bready1", bready, 1'b0);
        awready = 0;
        cyc();
        chk("skew_valids2", {awvalid, wvalid}, 2'b01);
        cyc();
        chk("skew_valids3", {awvalid, wvalid}, 2'b01);
        chk("skew_bready3", bready, 1'b0);
        wready = 1;
        cyc();
        chk("skew_valids4", {awvalid, wvalid}, 2'b00);
        chk("skew_bready4", bready, 1'b1);
        bvalid = 1; bresp = 2'b10; wready = 0;
        cyc();
        chk("slverr_ack", ack, 2'b01);
        chk("slverr_resp", resp, 2'b10);
        bvalid = 0; bresp = 0; req = 2'b00;
        cyc();

        // Both requesting continuously from reset: 0,1,0,1
        resetn = 1'b0; req = 2'b11; req_we = 2'b01;
        awready = 1; wready = 1; bvalid = 1; arready = 1; rvalid = 1; m_rdata = 32'hC0FFEE00;
        cyc(); cyc();
        chk("rr_rst_ack", ack, 2'b00);
        resetn = 1'b1;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            cyc();
            if (ack !== 2'b00) begin
                exp_ack = (n % 2 == 0) ? 2'b01 : 2'b10;
                chk($sformatf("rr_ack%0d", n), ack, exp_ack);
                n++;
            end
        end
        chk("rr_count", n, 4);

        // Reset during RD_D aborts the read; a fresh read then completes
        resetn = 1'b0; req = 2'b00; req_we = 2'b00;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; m_rdata = '0;
        cyc(); cyc();
        resetn = 1'b1; req = 2'b01; req_addr[AW-1:0] = 12'h008; arready = 1;
        cyc();
        chk("abort_arvalid", arvalid, 1'b1);
        cyc();
        chk("abort_rready_pre", rready, 1'b1);
        resetn = 1'b0; rvalid = 1; m_rdata = 32'hDEADBEEF;
        cyc();
        chk("abort_rready", rready, 1'b0);
        chk("abort_ack", ack, 2'b00);
        chk("abort_rdata", rdata, 32'h0);
        resetn = 1'b1; rvalid = 0; m_rdata = '0; req = 2'b00;
        cyc();
        chk("abort_no_ack", ack, 2'b00);
        chk("abort_idle", arvalid, 1'b0);
        req = 2'b01;
        cyc();
        chk("fresh_arvalid", arvalid, 1'b1);
        cyc();
        chk("fresh_rready", rready, 1'b1);
        rvalid = 1; m_rdata = 32'h0BADF00D; rresp = 2'b00;
        cyc();
        chk("fresh_ack", ack, 2'b01);
        chk("fresh_rdata", rdata, 32'h0BADF00D);
        chk("fresh_resp", resp, 2'b00);
        rvalid = 0; req = 2'b00;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axilite_master_arbiter.md
AXILITE_MASTER_ARBITER -- requirements
Module: axilite_master_arbiter

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data width of the requester side and the master side.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 12, address width of the requester side and the master side.
REQ-003 S_AXI_ACLK  in  1  single clock; all logic is on the rising edge.
REQ-004 S_AXI_ARESETN  in  1  reset, synchronous, active-low.
REQ-005 REQ  in  2  per-requester request; bit i is requester i.
REQ-006 REQ_WE  in  2  per-requester direction: 1 = write, 0 = read.
REQ-007 REQ_ADDR  in  2*ADDR_WIDTH  per-requester address; requester i uses slice i.
REQ-008 REQ_WDATA  in  2*DATA_WIDTH  per-requester write data; requester i uses slice i.
REQ-009 ACK  out  2  one-cycle completion pulse to the granted requester.
REQ-010 RDATA  out  DATA_WIDTH  read data, shared by both requesters.
REQ-011 RESP  out  2  response of the completed transaction (BRESP or RRESP).
REQ-012 M_AXI_AWADDR  out  ADDR_WIDTH  write address.
REQ-013 M_AXI_AWVALID  out  1  write address valid.
REQ-014 M_AXI_AWREADY  in  1  write address ready.
REQ-015 M_AXI_WDATA  out  DATA_WIDTH  write data.
REQ-016 M_AXI_WSTRB  out  DATA_WIDTH/8  write strobe; driven all ones.
REQ-017 M_AXI_WVALID  out  1  write data valid.
REQ-018 M_AXI_WREADY  in  1  write data ready.
REQ-019 M_AXI_BRESP  in  2  write response.
REQ-020 M_AXI_BVALID  in  1  write response valid.
REQ-021 M_AXI_BREADY  out  1  write response ready.
REQ-022 M_AXI_ARADDR  out  ADDR_WIDTH  read address.
REQ-023 M_AXI_ARVALID  out  1  read address valid.
REQ-024 M_AXI_ARREADY  in  1  read address ready.
REQ-025 M_AXI_RDATA  in  DATA_WIDTH  read data.
REQ-026 M_AXI_RRESP  in  2  read response.
REQ-027 M_AXI_RVALID  in  1  read data valid.
REQ-028 M_AXI_RREADY  out  1  read data ready.

Function
REQ-029 States SHALL be IDLE, WR, WAIT_B, RD_A, RD_D and DONE.
REQ-030 REQ SHALL be sampled only in IDLE; a REQ that drops before it is granted is discarded.
REQ-031 Arbitration SHALL be round-robin: with both REQ bits high, the requester not granted last wins; a single REQ wins unconditionally.
REQ-032 On grant, the block SHALL latch the grant index, REQ_WE, address and data for that requester; latched values stay stable until DONE.
REQ-033 Transition from IDLE SHALL go to WR if the latched WE is 1, else to RD_A. The first VALID asserts in the cycle after REQ is sampled.
REQ-034 WR: AWVALID and WVALID SHALL assert together; each deasserts independently on its own READY handshake.
REQ-035 WR SHALL go to WAIT_B only after both the AW and W handshakes have completed, including when they complete in the same cycle.
REQ-036 WAIT_B: BREADY=1; on BVALID, capture BRESP into RESP, then go to DONE.
REQ-037 RD_A: ARVALID=1 until ARREADY, then go to RD_D.
REQ-038 RD_D: RREADY=1; on RVALID, capture RDATA and RRESP, then go to DONE.
REQ-039 DONE SHALL last exactly one cycle: ACK[grant]=1, then return to IDLE.
REQ-040 RDATA and RESP SHALL be valid in the ACK cycle and hold until the next capture.
REQ-041 A requester SHALL drop REQ at the edge that samples its ACK. The non-granted REQ is held pending and wins in the next IDLE.
REQ-042 SLVERR/DECERR responses SHALL be passed through on RESP with no retry and no timeout.

Reset
REQ-043 While S_AXI_ARESETN=0 at an edge: state=IDLE, all VALID/READY outputs 0, ACK=0, RDATA=0, RESP=0, last-grant=1 (so requester 0 wins first). This applies mid-transaction; no ACK is issued for an aborted transaction.

Verification
REQ-044 Requester 0 writes 0x000 = 0x55555555; AWREADY and WREADY arrive together, BVALID one cycle later -> AW/WVALID high one cycle after REQ, ACK=01 for one cycle, RESP=00.
REQ-045 Requester 1 reads 0x004; slave returns 0xAAAAAAAA with RRESP=00 -> ARVALID then RREADY, ACK=10, RDATA=0xAAAAAAAA.
REQ-046 Both REQ bits held high continuously from reset -> grant order 0,1,0,1, and each ACK goes only to its owner.
REQ-047 AWREADY 3 cycles before WREADY -> AWVALID drops after its handshake while WVALID holds, and BREADY asserts only after the WREADY handshake.
REQ-048 Write with BRESP=10 -> RESP=10 in the ACK cycle.
REQ-049 Reset asserted during RD_D -> RREADY=0 and ACK=0 at the next edge; after release, a fresh requester-0 read completes normally.
